mult_err_monitor: RTL

MULT_ERR_MONITOR -- requirements
Module: mult_err_monitor

---
 rtl/mult_err_pkg.sv | 5 +
 rtl/err_dist_8x8.sv | 14 +
 rtl/mult_err_monitor.sv | 87 ++++++++
 3 files changed

// File: rtl/mult_err_pkg.sv
// mult_err_pkg: shared FSM state encoding and product width for the multiplier error monitor
package mult_err_pkg;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;
endpackage

// File: rtl/err_dist_8x8.sv
// err_dist_8x8: exact 8x8 product (a_i,b_i -> prod_o) and absolute error distance (p_i,r_i -> ed_o)
module err_dist_8x8
  import mult_err_pkg::*;
(
  input  logic [7:0]        a_i,
  input  logic [7:0]        b_i,
  input  logic [PROD_W-1:0] p_i,
  input  logic [PROD_W-1:0] r_i,
  output logic [PROD_W-1:0] prod_o,
  output logic [PROD_W-1:0] ed_o
);
  assign prod_o = PROD_W'(a_i) * PROD_W'(b_i);
  assign ed_o   = (p_i >= r_i) ? p_i - r_i : r_i - p_i;
endmodule

// File: rtl/mult_err_monitor.sv
// mult_err_monitor: windowed error statistics (sum/max/nonzero count of |A*B-R|) over 2^WIN_LOG2 handshaked samples, reported via stat_valid/stat_ready
module mult_err_monitor
  import mult_err_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             A,
  input  logic [7:0]             B,
  input  logic [PROD_W-1:0]      R,
  output logic                   stat_valid,
  input  logic                   stat_ready,
  output logic [PROD_W+WIN_LOG2-1:0] sum_ed,
  output logic [PROD_W-1:0]      max_ed,
  output logic [WIN_LOG2:0]      err_cnt,
  output logic                   busy
);
  state_t state_q, state_d;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic s1_v_q, s2_v_q;
  logic [PROD_W-1:0] prod_q, r_q, ed_q, prod, ed;
  logic [PROD_W+WIN_LOG2-1:0] sum_q, sum_d;
  logic [PROD_W-1:0] max_q, max_d;
  logic [WIN_LOG2:0] err_q, err_d;
  logic xfer, clr;
  err_dist_8x8 u_ed (
    .a_i   (A),
    .b_i   (B),
    .p_i   (prod_q),
    .r_i   (r_q),
    .prod_o(prod),
    .ed_o  (ed)
  );
  assign in_ready   = state_q == ACCUM;
  assign stat_valid = state_q == REPORT;
  assign busy       = state_q != IDLE;
  assign xfer       = in_valid && in_ready;
  assign clr        = state_q == IDLE && start;
  assign sum_ed     = sum_q;
  assign max_ed     = max_q;
  assign err_cnt    = err_q;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? ACCUM : IDLE;
      ACCUM:   state_d = (xfer && &cnt_q) ? DRAIN : ACCUM;
      DRAIN:   state_d = (!s1_v_q && !s2_v_q) ? REPORT : DRAIN;
      REPORT:  state_d = stat_ready ? IDLE : REPORT;
      default: state_d = IDLE;
    endcase
    cnt_d = clr ? '0 : xfer ? cnt_q + 1'b1 : cnt_q;
    sum_d = clr ? '0 : s2_v_q ? sum_q + (PROD_W+WIN_LOG2)'(ed_q) : sum_q;
    max_d = clr ? '0 : (s2_v_q && ed_q > max_q) ? ed_q : max_q;
    err_d = clr ? '0 : (s2_v_q && ed_q != '0) ? err_q + 1'b1 : err_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      s1_v_q  <= 1'b0;
      s2_v_q  <= 1'b0;
      prod_q  <= '0;
      r_q     <= '0;
      ed_q    <= '0;
      sum_q   <= '0;
      max_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_v_q  <= xfer;
      s2_v_q  <= s1_v_q;
      if (xfer) begin
        prod_q <= prod;
        r_q    <= R;
      end
      if (s1_v_q) ed_q <= ed;
      sum_q   <= sum_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end
endmodule
